// File: rtl/rv32_memory_stage_pl.sv
// rtl/rv32_memory_stage_pl.sv - RV32 memory-access stage: store strobes, latency-tracked loads, faults
// Entries advance through READ_LATENCY+1 valid-tagged stages; read data is captured entering the last one.
module rv32_memory_stage_pl #(
  parameter int READ_LATENCY = 1,
  parameter int NUM_SRC      = 2,
  parameter int FAULT_EN     = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    stall_i,
  input  logic                    flush_i,
  input  logic                    valid_i,
  input  logic                    reg_write_i,
  input  logic                    fp_reg_write_i,
  input  logic                    memory_write_i,
  input  logic                    memory_read_i,
  input  logic [2:0]              result_source_i,
  input  logic [31:0]             alu_result_i,
  input  logic [31:0]             write_data_i,
  input  logic [31:0]             instr_i,
  input  logic [31:0]             pc_next_i,
  input  logic [31:0]             fpu_result_i,
  input  logic [32*NUM_SRC-1:0]   read_data_src_i,
  output logic [31:0]             memory_address_o,
  output logic [3:0]              memory_write_enable_o,
  output logic [31:0]             memory_write_data_o,
  output logic                    memory_read_o,
  output logic                    valid_o,
  output logic                    reg_write_o,
  output logic                    fp_reg_write_o,
  output logic [2:0]              result_source_o,
  output logic [31:0]             alu_result_o,
  output logic [31:0]             read_data_o,
  output logic [31:0]             instr_o,
  output logic [31:0]             pc_next_o,
  output logic [31:0]             fpu_result_o,
  output logic                    fault_o,
  output logic [31:0]             fault_addr_o
);
  localparam int NS = READ_LATENCY + 1;

  typedef struct packed {
    logic        valid;
    logic        reg_write;
    logic        fp_reg_write;
    logic        mem_read;
    logic        fault;
    logic [2:0]  result_source;
    logic [2:0]  src;
    logic [31:0] alu;
    logic [31:0] instr;
    logic [31:0] pc_next;
  } stage_t;

  stage_t      stage_q [NS];
  stage_t      entry_d;
  stage_t      last;
  logic [2:0]  funct3;
  logic [1:0]  addr_lo;
  logic [2:0]  src_idx;
  logic        misaligned;
  logic        unmapped;
  logic        fault_now;
  logic        issue;
  logic [3:0]  strobe;
  logic [31:0] cap_word;
  logic [31:0] rdata_q;
  logic [31:0] fpu_q;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign funct3   = instr_i[14:12];
  assign addr_lo  = alu_result_i[1:0];
  assign src_idx  = alu_result_i[31:29];
  assign unmapped = {1'b0, src_idx} >= 4'(NUM_SRC);

  always_comb begin
    misaligned = 1'b0;
    strobe     = 4'b1111;
    memory_write_data_o = write_data_i;
    case (funct3[1:0])
      2'b00: begin
        strobe = 4'b0001 << addr_lo;
        memory_write_data_o = {4{write_data_i[7:0]}};
      end
      2'b01: begin
        misaligned = addr_lo[0];
        strobe = addr_lo[1] ? 4'b1100 : 4'b0011;
        memory_write_data_o = {2{write_data_i[15:0]}};
      end
      2'b10:   misaligned = (addr_lo != 2'b00);
      default: misaligned = 1'b0;
    endcase
  end

  assign fault_now = (FAULT_EN != 0) && (memory_read_i || memory_write_i) && (misaligned || unmapped);
  assign issue     = valid_i && !stall_i && !flush_i && !fault_now;

  assign memory_address_o      = alu_result_i;
  assign memory_write_enable_o = (issue && memory_write_i) ? strobe : 4'b0000;
  assign memory_read_o         = issue && memory_read_i;

  always_comb begin
    entry_d               = '0;
    entry_d.valid         = valid_i;
    entry_d.reg_write     = reg_write_i;
    entry_d.fp_reg_write  = fp_reg_write_i;
    entry_d.mem_read      = memory_read_i;
    entry_d.fault         = valid_i && fault_now;
    entry_d.result_source = result_source_i;
    entry_d.src           = src_idx;
    entry_d.alu           = alu_result_i;
    entry_d.instr         = instr_i;
    entry_d.pc_next       = pc_next_i;
  end

  // Data for the entry in stage L is on the bus now; unmapped sources read as zero.
  always_comb begin
    cap_word = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      if (stage_q[NS-2].src == 3'(s)) cap_word = read_data_src_i[32*s +: 32];
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < NS; i++) stage_q[i] <= '0;
      rdata_q <= '0;
      fpu_q   <= '0;
    end else if (flush_i) begin
      for (int i = 0; i < NS; i++) stage_q[i].valid <= 1'b0;
    end else if (!stall_i) begin
      stage_q[0] <= entry_d;
      for (int i = 1; i < NS; i++) stage_q[i] <= stage_q[i-1];
      rdata_q <= cap_word;
      fpu_q   <= fpu_result_i;
    end
  end

  assign last = stage_q[NS-1];

  always_comb begin
    case (last.alu[1:0])
      2'd0:    ld_byte = rdata_q[7:0];
      2'd1:    ld_byte = rdata_q[15:8];
      2'd2:    ld_byte = rdata_q[23:16];
      default: ld_byte = rdata_q[31:24];
    endcase
    ld_half = last.alu[1] ? rdata_q[31:16] : rdata_q[15:0];
    read_data_o = rdata_q;
    if (last.mem_read) begin
      case (last.instr[14:12])
        3'b000:  read_data_o = {{24{ld_byte[7]}}, ld_byte};
        3'b100:  read_data_o = {24'd0, ld_byte};
        3'b001:  read_data_o = {{16{ld_half[15]}}, ld_half};
        3'b101:  read_data_o = {16'd0, ld_half};
        default: read_data_o = rdata_q;
      endcase
    end
  end

  assign valid_o         = last.valid;
  assign fault_o         = last.valid && last.fault;
  assign fault_addr_o    = fault_o ? last.alu : 32'd0;
  assign reg_write_o     = last.valid && last.reg_write && !last.fault;
  assign fp_reg_write_o  = last.valid && last.fp_reg_write && !last.fault;
  assign result_source_o = last.result_source;
  assign alu_result_o    = last.alu;
  assign instr_o         = last.instr;
  assign pc_next_o       = last.pc_next;
  assign fpu_result_o    = fpu_q;
endmodule

// File: tb/tb_rv32_memory_stage_pl.sv
// tb/tb_rv32_memory_stage_pl.sv - directed bench for rv32_memory_stage_pl (READ_LATENCY=2, NUM_SRC=2)
module tb_rv32_memory_stage_pl;
  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        stall_i, flush_i, valid_i, reg_write_i, fp_reg_write_i;
  logic        memory_write_i, memory_read_i;
  logic [2:0]  result_source_i;
  logic [31:0] alu_result_i, write_data_i, instr_i, pc_next_i, fpu_result_i;
  logic [63:0] read_data_src_i;
  logic [31:0] memory_address_o, memory_write_data_o, alu_result_o, read_data_o;
  logic [31:0] instr_o, pc_next_o, fpu_result_o, fault_addr_o;
  logic [3:0]  memory_write_enable_o;
  logic        memory_read_o, valid_o, reg_write_o, fp_reg_write_o, fault_o;
  logic [2:0]  result_source_o;

  int n_checks = 0;
  int n_fail   = 0;

  rv32_memory_stage_pl #(.READ_LATENCY(2), .NUM_SRC(2), .FAULT_EN(1)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .stall_i(stall_i), .flush_i(flush_i),
    .valid_i(valid_i), .reg_write_i(reg_write_i), .fp_reg_write_i(fp_reg_write_i),
    .memory_write_i(memory_write_i), .memory_read_i(memory_read_i),
    .result_source_i(result_source_i), .alu_result_i(alu_result_i),
    .write_data_i(write_data_i), .instr_i(instr_i), .pc_next_i(pc_next_i),
    .fpu_result_i(fpu_result_i), .read_data_src_i(read_data_src_i),
    .memory_address_o(memory_address_o), .memory_write_enable_o(memory_write_enable_o),
    .memory_write_data_o(memory_write_data_o), .memory_read_o(memory_read_o),
    .valid_o(valid_o), .reg_write_o(reg_write_o), .fp_reg_write_o(fp_reg_write_o),
    .result_source_o(result_source_o), .alu_result_o(alu_result_o),
    .read_data_o(read_data_o), .instr_o(instr_o), .pc_next_o(pc_next_o),
    .fpu_result_o(fpu_result_o), .fault_o(fault_o), .fault_addr_o(fault_addr_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    stall_i = 0; flush_i = 0; valid_i = 0; reg_write_i = 0; fp_reg_write_i = 0;
    memory_write_i = 0; memory_read_i = 0; result_source_i = 0;
    alu_result_i = 0; write_data_i = 0; instr_i = 0; pc_next_i = 0; fpu_result_i = 0;
  endtask

  task automatic load(input logic [2:0] f3, input logic [31:0] addr);
    valid_i = 1; memory_read_i = 1; reg_write_i = 1; result_source_i = 3'd1;
    instr_i = {17'd0, f3, 12'd0}; alu_result_i = addr;
  endtask

  task automatic store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
    valid_i = 1; memory_write_i = 1; instr_i = {17'd0, f3, 12'd0};
    alu_result_i = addr; write_data_i = wd;
  endtask

  task automatic test_reset();
    rst_n_i = 0; idle(); read_data_src_i = '0;
    tick(); tick();
    n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", valid_o); end
    n_checks++; if (fault_o !== 1'b0) begin n_fail++; $display("FAIL reset_fault: got %0b want 0", fault_o); end
    n_checks++; if (read_data_o !== 32'd0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", read_data_o); end
    n_checks++; if (alu_result_o !== 32'd0 || reg_write_o !== 1'b0) begin n_fail++; $display("FAIL reset_regs: alu %h rw %0b want 0/0", alu_result_o, reg_write_o); end
    rst_n_i = 1;
    tick();
  endtask

  task automatic test_store_strobes();
    store(3'b000, 32'h0000_0002, 32'h0000_00A5); #1;
    n_checks++; if (memory_write_enable_o !== 4'b0100) begin n_fail++; $display("FAIL sb_strobe: got %b want 0100", memory_write_enable_o); end
    n_checks++; if (memory_write_data_o !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL sb_data: got %h want a5a5a5a5", memory_write_data_o); end
    n_checks++; if (memory_address_o !== 32'h2) begin n_fail++; $display("FAIL sb_addr: got %h want 2", memory_address_o); end
    store(3'b001, 32'h0000_0002, 32'hFFFF_1234); #1;
    n_checks++; if (memory_write_enable_o !== 4'b1100 || memory_write_data_o !== 32'h12341234) begin n_fail++; $display("FAIL sh_store: got %b/%h want 1100/12341234", memory_write_enable_o, memory_write_data_o); end
    store(3'b010, 32'h0000_0004, 32'hDEADBEEF); #1;
    n_checks++; if (memory_write_enable_o !== 4'b1111 || memory_write_data_o !== 32'hDEADBEEF) begin n_fail++; $display("FAIL sw_store: got %b/%h want 1111/deadbeef", memory_write_enable_o, memory_write_data_o); end
    stall_i = 1; #1;
    n_checks++; if (memory_write_enable_o !== 4'b0000) begin n_fail++; $display("FAIL stall_gate: got %b want 0000", memory_write_enable_o); end
    stall_i = 0; flush_i = 1; #1;
    n_checks++; if (memory_write_enable_o !== 4'b0000) begin n_fail++; $display("FAIL flush_gate: got %b want 0000", memory_write_enable_o); end
    idle(); tick(); tick(); tick(); tick();
  endtask

  task automatic test_load_lb();
    read_data_src_i = {32'h0, 32'h80FF_FFFF};
    load(3'b000, 32'h0000_0003); pc_next_i = 32'h104; #1;
    n_checks++; if (memory_read_o !== 1'b1) begin n_fail++; $display("FAIL lb_rd_strobe: got %0b want 1", memory_read_o); end
    tick(); idle();
    tick();
    n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL lb_early: valid_o %0b want 0 after 2 cycles", valid_o); end
    fpu_result_i = 32'hCAFEF00D;
    tick(); fpu_result_i = 0;
    n_checks++; if (valid_o !== 1'b1 || reg_write_o !== 1'b1) begin n_fail++; $display("FAIL lb_valid: got v%0b rw%0b want 1/1", valid_o, reg_write_o); end
    n_checks++; if (read_data_o !== 32'hFFFFFF80) begin n_fail++; $display("FAIL lb_data: got %h want ffffff80", read_data_o); end
    n_checks++; if (fpu_result_o !== 32'hCAFEF00D || pc_next_o !== 32'h104) begin n_fail++; $display("FAIL lb_side: fpu %h pc %h want cafef00d/104", fpu_result_o, pc_next_o); end
    tick();
    n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL lb_retire: valid_o %0b want 0", valid_o); end
  endtask

  task automatic test_lhu_and_unmapped();
    read_data_src_i = {32'hBEEF_1234, 32'h0};
    load(3'b101, 32'h2000_0002);
    tick(); idle(); tick(); tick();
    n_checks++; if (valid_o !== 1'b1 || fault_o !== 1'b0 || read_data_o !== 32'h0000BEEF) begin n_fail++; $display("FAIL lhu_src1: v%0b f%0b data %h want 1/0/0000beef", valid_o, fault_o, read_data_o); end
    load(3'b101, 32'h4000_0000); #1;
    n_checks++; if (memory_read_o !== 1'b0) begin n_fail++; $display("FAIL unmapped_strobe: got %0b want 0", memory_read_o); end
    tick(); idle(); tick(); tick();
    n_checks++; if (valid_o !== 1'b1 || fault_o !== 1'b1 || fault_addr_o !== 32'h4000_0000) begin n_fail++; $display("FAIL unmapped_fault: v%0b f%0b addr %h want 1/1/40000000", valid_o, fault_o, fault_addr_o); end
    n_checks++; if (reg_write_o !== 1'b0 || read_data_o !== 32'd0) begin n_fail++; $display("FAIL unmapped_wb: rw %0b data %h want 0/0", reg_write_o, read_data_o); end
    tick();
  endtask

  task automatic test_sw_misaligned();
    store(3'b010, 32'h0000_0006, 32'h1234_5678); reg_write_i = 1; #1;
    n_checks++; if (memory_write_enable_o !== 4'b0000) begin n_fail++; $display("FAIL sw_mis_strobe: got %b want 0000", memory_write_enable_o); end
    tick(); idle(); tick();
    n_checks++; if (fault_o !== 1'b0) begin n_fail++; $display("FAIL sw_mis_early: fault_o %0b want 0", fault_o); end
    tick();
    n_checks++; if (fault_o !== 1'b1 || fault_addr_o !== 32'h6 || reg_write_o !== 1'b0) begin n_fail++; $display("FAIL sw_mis_fault: f%0b addr %h rw%0b want 1/6/0", fault_o, fault_addr_o, reg_write_o); end
    tick();
  endtask

  task automatic test_stall();
    read_data_src_i = {32'h2222_2222, 32'h1111_1111};
    load(3'b010, 32'h0000_0000); tick();
    load(3'b010, 32'h2000_0000); tick();
    idle(); tick();
    n_checks++; if (valid_o !== 1'b1 || read_data_o !== 32'h11111111) begin n_fail++; $display("FAIL stall_first: v%0b data %h want 1/11111111", valid_o, read_data_o); end
    stall_i = 1; load(3'b010, 32'h0000_0004); #1;
    n_checks++; if (memory_read_o !== 1'b0) begin n_fail++; $display("FAIL stall_rd_strobe: got %0b want 0", memory_read_o); end
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++; if (valid_o !== 1'b1 || read_data_o !== 32'h11111111 || alu_result_o !== 32'h0) begin n_fail++; $display("FAIL stall_hold%0d: v%0b data %h alu %h want 1/11111111/0", c, valid_o, read_data_o, alu_result_o); end
    end
    idle(); tick();
    n_checks++; if (valid_o !== 1'b1 || read_data_o !== 32'h22222222 || alu_result_o !== 32'h2000_0000) begin n_fail++; $display("FAIL stall_second: v%0b data %h alu %h want 1/22222222/20000000", valid_o, read_data_o, alu_result_o); end
    tick();
    n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL stall_drain: valid_o %0b want 0", valid_o); end
  endtask

  task automatic test_flush();
    read_data_src_i = {32'h00C3_0000, 32'h1111_1111};
    load(3'b010, 32'h0000_0000); tick();
    flush_i = 1; load(3'b010, 32'h0000_0008); #1;
    n_checks++; if (memory_read_o !== 1'b0) begin n_fail++; $display("FAIL flush_rd_strobe: got %0b want 0", memory_read_o); end
    tick();
    idle(); load(3'b100, 32'h2000_0002); tick();
    idle();
    n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_drop1: valid_o %0b want 0", valid_o); end
    tick();
    n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_drop2: valid_o %0b want 0", valid_o); end
    tick();
    n_checks++; if (valid_o !== 1'b1 || read_data_o !== 32'h000000C3 || reg_write_o !== 1'b1) begin n_fail++; $display("FAIL flush_next: v%0b data %h rw%0b want 1/000000c3/1", valid_o, read_data_o, reg_write_o); end
    tick();
  endtask

  initial begin
    test_reset();
    test_store_strobes();
    test_load_lb();
    test_lhu_and_unmapped();
    test_sw_misaligned();
    test_stall();
    test_flush();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
